fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one async FIFO among NUM_REQ requesters in the FIFO's write clock domain. Each requester presents beats with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and passes its beats straight through to the FIFO write port, honouring wfull. It sits directly in front of the FIFO's wen/wdata/wfull pins, so several producers can feed one clock-crossing buffer.

## Interface
- NUM_REQ, 4: number of requesters, >= 2
- DATA_WIDTH, 8: beat width per requester
- MAX_BURST, 4: maximum beats per grant, >= 1
- clk  in  1  write-domain clock (the FIFO's wclk); single clock for the block
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ x DATA_WIDTH  per-requester beat data
- req_last  in  NUM_REQ  beat is the final beat of the requester's packet
- req_ready  out  NUM_REQ  beat accepted when valid & ready
- fifo_wen  out  1  FIFO write enable
- fifo_wdata  out  FIFO_W  FIFO write data; FIFO_W = DATA_WIDTH, or DATA_WIDTH+ID_W with tagging
- fifo_wfull  in  1  FIFO full flag (registered in the FIFO)
- grant_id  out  ID_W  index of the current owner; ID_W = max(1, clog2(NUM_REQ))
- busy  out  1  a grant is held (state GRANT)

## Operation
- States: IDLE, GRANT. Registers: state, gnt (ID_W), rr_ptr (ID_W), beat_cnt (clog2(MAX_BURST+1)).
- IDLE: search requesters rr_ptr, rr_ptr+1, … (mod NUM_REQ) and pick the first with req_valid=1. On a hit, latch gnt and go to GRANT with beat_cnt=0. With no valid requester, stay in IDLE.
- GRANT:
  - req_ready[gnt] = ~fifo_wfull. All other ready bits are 0.
  - fifo_wen = req_valid[gnt] & ~fifo_wfull. fifo_wdata = req_data[gnt].
  - A transfer is valid & ready on gnt. Each transfer increments beat_cnt.
- Release from GRANT to IDLE happens on whichever comes first:
  - a transfer with req_last[gnt]=1;
  - a transfer that makes beat_cnt reach MAX_BURST;
  - req_valid[gnt]=0 in GRANT. The owner dropping valid forfeits its turn.
- On release, rr_ptr <= gnt+1 mod NUM_REQ and beat_cnt <= 0.
- fifo_wfull=1 in GRANT: no transfer and no release. The grant is held and waits for space; this is a backpressure stall, not a forfeit.
- Outside GRANT: req_ready=0 and fifo_wen=0. fifo_wdata is don't-care, driven as req_data[gnt].
- Fairness: a requester that is continuously valid is granted within NUM_REQ-1 grants of others.

## Timing
- Reset values: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0; req_ready=0, fifo_wen=0, grant_id=0, busy=0.
- While reset=1, req_ready and fifo_wen are forced to 0 combinationally, including a reset asserted mid-burst. The partial packet is abandoned and no beat is written.
- Arbitration latency: a valid in IDLE at edge k gives busy=1 after edge k. The first transfer can happen in the cycle after edge k.
- Pass-through has zero latency: fifo_wen, fifo_wdata and req_ready are combinational from the registered state/gnt and the current inputs.
- One bubble cycle (IDLE) between consecutive grants.
- MAX_BURST=1: every transfer releases.
- A transfer that is both last and the MAX_BURST-th beat releases once. rr_ptr advances by 1.
- grant_id = gnt and busy = (state==GRANT), both registered.

## Configuration
- FIFO_ARB_TAG_EN defined:
  - fifo_wdata = {gnt, req_data[gnt]}, with the ID in the MSBs, so FIFO_W = DATA_WIDTH+ID_W.
  - The FIFO instance's DATA_WIDTH must be set to match.
- Undefined: fifo_wdata = req_data[gnt] and FIFO_W = DATA_WIDTH.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - a clog2-based function for ID_W and beat_cnt width.
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs hit and index. It is instantiated once for the IDLE search.

## Test plan
- Reset, then NUM_REQ=4 with only req 2 valid, 3 beats, last on beat 3 -> busy rises 1 cycle later. fifo_wen pulses 3 cycles with the data in order. rr_ptr becomes 3 and the block returns to IDLE.
- All 4 requesters continuously valid, MAX_BURST=4, no last -> grants 0,1,2,3,0 in that order. Exactly 4 beats each, with one IDLE cycle between grants.
- Req 1 granted, fifo_wfull=1 for 5 cycles mid-burst -> req_ready[1]=0 and fifo_wen=0 for those cycles. The grant is kept and the burst resumes when full deasserts, with beat count unchanged.
- Owner drops valid after 1 beat while req 3 is valid -> release. Req 3 is granted after the IDLE cycle, and the owner loses its remaining 3 beats.
- reset asserted on beat 2 of a burst -> fifo_wen=0 in that same cycle. All outputs take their reset values after the edge, and the next grant starts from requester 0.
- With FIFO_ARB_TAG_EN, req 3 sends 0xA5 -> fifo_wdata = {2'b11, 8'hA5}. Without the macro -> 8'hA5.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never less than 1 so single-value fields stay 1 bit wide
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request at or after i_ptr, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_hit,
  output logic [IW-1:0] o_idx
);

  int w_pos;

  // Scan from the farthest offset down so the nearest hit to i_ptr wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (i_req[w_pos]) begin
        o_hit = 1'b1;
        o_idx = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_TAG_EN to prepend the owner ID to every written beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = clog2_min1(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
  localparam int FIFO_W    = DATA_WIDTH + ID_W
`else
  localparam int FIFO_W    = DATA_WIDTH
`endif
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                fifo_wen,
  output logic [FIFO_W-1:0]                   fifo_wdata,
  input  logic                                fifo_wfull,
  output logic [ID_W-1:0]                     grant_id,
  output logic                                busy
);

  localparam int              CNT_W      = clog2_min1(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

  arb_state_e       r_state;
  logic [ID_W-1:0]  r_gnt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_hit;
  logic [ID_W-1:0]  w_pick;
  logic             w_granted;
  logic             w_own_valid;
  logic             w_own_last;
  logic             w_xfer;
  logic             w_release;
  logic [ID_W-1:0]  w_next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_hit (w_hit),
    .o_idx (w_pick)
  );

  assign w_granted   = (r_state == GRANT);
  assign w_own_valid = req_valid[r_gnt];
  assign w_own_last  = req_last[r_gnt];

  // Reset gates the handshake combinationally so a burst cut by reset writes nothing.
  assign w_xfer     = w_granted & w_own_valid & ~fifo_wfull & ~reset;
  assign w_release  = w_granted & ~fifo_wfull &
                      (~w_own_valid | w_own_last | (r_beat_cnt == BURST_LAST));
  assign w_next_ptr = (r_gnt == LAST_ID) ? '0 : r_gnt + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_granted && !reset) req_ready[r_gnt] = ~fifo_wfull;
  end

  assign fifo_wen = w_xfer;

`ifdef FIFO_ARB_TAG_EN
  assign fifo_wdata = {r_gnt, req_data[r_gnt]};
`else
  assign fifo_wdata = req_data[r_gnt];
`endif

  assign grant_id = r_gnt;
  assign busy     = w_granted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_gnt      <= w_pick;
            r_state    <= GRANT;
            r_beat_cnt <= '0;
          end
        end
        GRANT: begin
          // A full FIFO freezes the grant: neither a transfer nor a forfeit.
          if (w_release) begin
            r_state    <= IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: randomized producers against a reference model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int ID_W = clog2_min1(N);
`ifdef FIFO_ARB_TAG_EN
  localparam int FIFO_W = DW + ID_W;
`else
  localparam int FIFO_W = DW;
`endif

  logic                   clk;
  logic                   reset;
  logic [N-1:0]           req_valid;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_last;
  logic [N-1:0]           req_ready;
  logic                   fifo_wen;
  logic [FIFO_W-1:0]      fifo_wdata;
  logic                   fifo_wfull;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            busy;
    logic [ID_W-1:0] gid;
    logic [N-1:0]    rdy;
    logic            wen;
  } cyc_t;

  cyc_t              exp_cyc[$];
  logic [FIFO_W-1:0] exp_data[$];
  int                vectors;
  int                miscompares;

  // Reference model: owner -1 means nobody holds the port
  int           m_owner;
  int           m_gid;
  int           m_ptr;
  int           m_cnt;
  logic [N-1:0] acc;

  function automatic logic pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic model_step();
    cyc_t e;
    int   r;
    e.busy = (m_owner >= 0);
    e.gid  = ID_W'(m_gid);
    e.rdy  = '0;
    e.wen  = 1'b0;
    acc    = '0;
    if (reset) begin
      m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_owner >= 0) begin
      if (!fifo_wfull) begin
        e.rdy[m_owner] = 1'b1;
        if (!req_valid[m_owner]) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
        end else begin
          e.wen = 1'b1;
          acc[m_owner] = 1'b1;
`ifdef FIFO_ARB_TAG_EN
          exp_data.push_back({ID_W'(m_owner), req_data[m_owner]});
`else
          exp_data.push_back(req_data[m_owner]);
`endif
          m_cnt++;
          if (req_last[m_owner] || m_cnt == MB) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
          end
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (m_owner < 0 && req_valid[r]) begin
          m_owner = r; m_gid = r; m_cnt = 0;
        end
      end
    end
    exp_cyc.push_back(e);
  endtask

  // One cycle of producer behaviour, then the model's prediction for that cycle.
  task automatic drive_cycle(input int p_valid, input int p_last, input int p_full,
                             input int p_drop, input int p_rst, input logic [N-1:0] mask);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        req_valid[i] = 1'b0;
      end else if (acc[i]) begin
        req_data[i]  = DW'($urandom);
        req_last[i]  = pct(p_last);
        req_valid[i] = pct(p_valid);
      end else if (req_valid[i]) begin
        if (pct(p_drop)) req_valid[i] = 1'b0;
      end else if (pct(p_valid)) begin
        req_data[i]  = DW'($urandom);
        req_last[i]  = pct(p_last);
        req_valid[i] = 1'b1;
      end
    end
    fifo_wfull = pct(p_full);
    reset      = pct(p_rst);
    model_step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    cyc_t e;
    forever begin
      @(negedge clk);
      if (exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        check("busy",      32'(busy),      32'(e.busy));
        check("grant_id",  32'(grant_id),  32'(e.gid));
        check("req_ready", 32'(req_ready), 32'(e.rdy));
        check("fifo_wen",  32'(fifo_wen),  32'(e.wen));
        if (fifo_wen === 1'b1) begin
          if (exp_data.size() == 0) begin
            check("fifo_wdata_unexpected", 32'(fifo_wdata), 32'hFFFF_FFFF);
          end else begin
            check("fifo_wdata", 32'(fifo_wdata), 32'(exp_data.pop_front()));
          end
        end
      end
    end
  end

  initial begin : stimulus
    vectors = 0; miscompares = 0;
    m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0;
    acc = '0;
    reset = 1'b1; fifo_wfull = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;

    // reset hold, then a single producer (requester 2)
    for (int c = 0; c < 3; c++)   drive_cycle(0, 0, 0, 0, 100, 4'b0000);
    for (int c = 0; c < 40; c++)  drive_cycle(100, 30, 0, 0, 0, 4'b0100);
    // all requesters saturating: pure round-robin with full bursts
    for (int c = 0; c < 60; c++)  drive_cycle(100, 0, 0, 0, 0, 4'b1111);
    // heavy backpressure
    for (int c = 0; c < 80; c++)  drive_cycle(100, 20, 50, 0, 0, 4'b1111);
    // owners dropping valid mid-packet
    for (int c = 0; c < 80; c++)  drive_cycle(70, 20, 10, 30, 0, 4'b1111);
    // mixed traffic with occasional mid-burst resets
    for (int c = 0; c < 2000; c++) drive_cycle(60, 25, 20, 10, 2, 4'b1111);
    for (int c = 0; c < 4; c++)   drive_cycle(0, 0, 0, 0, 0, 4'b0000);

    @(negedge clk);
    #1;
    check("leftover_expected_beats", 32'(exp_data.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
